// File: rtl/qdec_ctx_mem_arb.sv
// qdec_ctx_mem_arb
//   Arbitrates the single-port CABAC context RAM between the context-init
//   writer, the arithmetic-decoder read port and the state-update writeback.
//   Writebacks go into a small FIFO so reads win the port; reads that hit a
//   buffered address are forwarded from the FIFO with the same latency as a
//   memory read.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   init_vld/addr/wdata/rdy     context-init write request / accept
//   rd_vld/addr/rdy             context read request / accept
//   rsp_vld/data                read response (in order, one cycle each)
//   wb_vld/addr/wdata/rdy       writeback request / accept
//   wb_empty                    write buffer empty
//   ctx_addr/wdata/we/re        registered memory command
//   ctx_rdata                   memory read data (MEM_RD_LAT after ctx_re)

module qdec_ctx_mem_arb #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int WB_DEPTH   = 2,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_vld,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata,
  output logic              init_rdy,
  input  logic              rd_vld,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rdy,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_vld,
  input  logic              wb_vld,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              wb_rdy,
  output logic              wb_empty,
  output logic [ADDR_W-1:0] ctx_addr,
  output logic [DATA_W-1:0] ctx_wdata,
  output logic              ctx_we,
  output logic              ctx_re,
  input  logic [DATA_W-1:0] ctx_rdata
);

  localparam int CNT_W  = $clog2(WB_DEPTH + 1);
  localparam int PIPE_D = MEM_RD_LAT + 1;

  typedef enum logic [2:0] {
    G_NONE, G_INIT, G_READ, G_DRAIN, G_DRAIN_FORCE
  } grant_t;

  grant_t grant;

  // Write buffer kept as a shift FIFO: entry 0 is the oldest.
  logic [ADDR_W-1:0] wb_addr_q [WB_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WB_DEPTH];
  logic [CNT_W-1:0]  wb_cnt;
  logic [CNT_W-1:0]  wr_idx;

  logic buf_full, buf_empty, drain, push;
  logic fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  logic [PIPE_D-1:0] pipe_vld, pipe_hit;
  logic [DATA_W-1:0] pipe_data [PIPE_D];

  assign buf_full  = (wb_cnt == CNT_W'(WB_DEPTH));
  assign buf_empty = (wb_cnt == '0);

  always_comb begin
    grant = G_NONE;
    if (buf_full && wb_vld)       grant = G_DRAIN_FORCE;
    else if (init_vld && buf_empty) grant = G_INIT;
    else if (init_vld)            grant = G_DRAIN_FORCE;
    else if (rd_vld)              grant = G_READ;
    else if (!buf_empty)          grant = G_DRAIN;
  end

  assign drain    = (grant == G_DRAIN) || (grant == G_DRAIN_FORCE);
  assign init_rdy = (grant == G_INIT);
  assign rd_rdy   = (grant == G_READ);
  assign wb_rdy   = !buf_full || drain;
  assign wb_empty = buf_empty;
  assign push     = wb_vld && wb_rdy;
  // On a simultaneous pop the new entry lands one slot lower.
  assign wr_idx   = wb_cnt - CNT_W'(drain);

  // Newest matching entry wins: later (younger) slots override earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if ((CNT_W'(i) < wb_cnt) && (wb_addr_q[i] == rd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_cnt <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
    end else begin
      if (drain) begin
        for (int i = 0; i < WB_DEPTH - 1; i++) begin
          wb_addr_q[i] <= wb_addr_q[i+1];
          wb_data_q[i] <= wb_data_q[i+1];
        end
      end
      for (int i = 0; i < WB_DEPTH; i++) begin
        if (push && (CNT_W'(i) == wr_idx)) begin
          wb_addr_q[i] <= wb_addr;
          wb_data_q[i] <= wb_wdata;
        end
      end
      wb_cnt <= wb_cnt + CNT_W'(push) - CNT_W'(drain);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx_we    <= 1'b0;
      ctx_re    <= 1'b0;
      ctx_addr  <= '0;
      ctx_wdata <= '0;
    end else begin
      ctx_we <= 1'b0;
      ctx_re <= 1'b0;
      case (grant)
        G_INIT: begin
          ctx_we    <= 1'b1;
          ctx_addr  <= init_addr;
          ctx_wdata <= init_wdata;
        end
        G_DRAIN, G_DRAIN_FORCE: begin
          ctx_we    <= 1'b1;
          ctx_addr  <= wb_addr_q[0];
          ctx_wdata <= wb_data_q[0];
        end
        G_READ: begin
          if (!fwd_hit) begin
            ctx_re   <= 1'b1;
            ctx_addr <= rd_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // Response pipe: forwarded hits travel alongside misses so both
  // answer after the same number of cycles and stay in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      pipe_hit <= '0;
      for (int i = 0; i < PIPE_D; i++) pipe_data[i] <= '0;
    end else begin
      pipe_vld[0]  <= (grant == G_READ);
      pipe_hit[0]  <= fwd_hit;
      pipe_data[0] <= fwd_data;
      for (int i = 1; i < PIPE_D; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_hit[i]  <= pipe_hit[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign rsp_vld  = pipe_vld[PIPE_D-1];
  assign rsp_data = pipe_hit[PIPE_D-1] ? pipe_data[PIPE_D-1] : ctx_rdata;

endmodule

// File: tb/tb_qdec_ctx_mem_arb.sv
module tb_qdec_ctx_mem_arb;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int LAT   = 1;

  logic          clk, rst_n;
  logic          init_vld, init_rdy, rd_vld, rd_rdy, rsp_vld;
  logic          wb_vld, wb_rdy, wb_empty, ctx_we, ctx_re;
  logic [AW-1:0] init_addr, rd_addr, wb_addr, ctx_addr;
  logic [DW-1:0] init_wdata, rsp_data, wb_wdata, ctx_wdata, ctx_rdata;

  qdec_ctx_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .WB_DEPTH(DEPTH), .MEM_RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_vld(init_vld), .init_addr(init_addr), .init_wdata(init_wdata), .init_rdy(init_rdy),
    .rd_vld(rd_vld), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .rsp_data(rsp_data), .rsp_vld(rsp_vld),
    .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdy(wb_rdy),
    .wb_empty(wb_empty),
    .ctx_addr(ctx_addr), .ctx_wdata(ctx_wdata), .ctx_we(ctx_we), .ctx_re(ctx_re),
    .ctx_rdata(ctx_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Context RAM (environment), MEM_RD_LAT = 1.
  logic [DW-1:0] ram [1024];
  logic          ram_fill;

  function automatic logic [DW-1:0] ram_init_val(int i);
    if (i == 18) return 8'hA5;
    if (i == 80) return 8'h22;
    return 8'(i * 37 + 5);
  endfunction

  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 1024; i++) ram[i] <= ram_init_val(i);
    end else begin
      if (ctx_we) ram[ctx_addr] <= ctx_wdata;
      if (ctx_re) ctx_rdata <= ram[ctx_addr];
    end
  end

  // Reference model: memory image updated at grant time, buffer as a
  // queue, responses as a queue of (due cycle, value).
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  typedef struct { int due; logic [DW-1:0] d; } rsp_t;

  logic [DW-1:0] ref_mem [1024];
  ent_t          q[$];
  rsp_t          rq[$];
  logic          exp_we, exp_re;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  int            cyc, last_g;
  int            checks, errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    init_vld = 1'b0; rd_vld = 1'b0; wb_vld = 1'b0;
  endtask

  // One clock cycle: inputs already driven; check at negedge, advance model.
  task automatic step();
    int n, g;
    logic hit, ev, exp_wbr;
    logic [DW-1:0] v;
    ent_t e;
    rsp_t r;
    @(negedge clk);
    chk("ctx_we", 32'(ctx_we), 32'(exp_we));
    chk("ctx_re", 32'(ctx_re), 32'(exp_re));
    if (exp_we) begin
      chk("ctx_addr_wr", 32'(ctx_addr), 32'(exp_addr));
      chk("ctx_wdata", 32'(ctx_wdata), 32'(exp_data));
    end
    if (exp_re) chk("ctx_addr_rd", 32'(ctx_addr), 32'(exp_addr));
    ev = (rq.size() > 0) && (rq[0].due == cyc);
    chk("rsp_vld", 32'(rsp_vld), 32'(ev));
    if (ev) begin
      chk("rsp_data", 32'(rsp_data), 32'(rq[0].d));
      void'(rq.pop_front());
    end

    n = q.size();
    if (n == DEPTH && wb_vld)    g = 3;
    else if (init_vld && n == 0) g = 1;
    else if (init_vld)           g = 3;
    else if (rd_vld)             g = 2;
    else if (n > 0)              g = 3;
    else                         g = 0;
    exp_wbr = (n < DEPTH) || (g == 3);
    chk("init_rdy", 32'(init_rdy), 32'(g == 1));
    chk("rd_rdy", 32'(rd_rdy), 32'(g == 2));
    chk("wb_rdy", 32'(wb_rdy), 32'(exp_wbr));
    chk("wb_empty", 32'(wb_empty), 32'(n == 0));

    exp_we = 1'b0;
    exp_re = 1'b0;
    if (g == 1) begin
      exp_we = 1'b1; exp_addr = init_addr; exp_data = init_wdata;
      ref_mem[init_addr] = init_wdata;
    end else if (g == 3) begin
      e = q.pop_front();
      exp_we = 1'b1; exp_addr = e.a; exp_data = e.d;
      ref_mem[e.a] = e.d;
    end else if (g == 2) begin
      hit = 1'b0;
      v = ref_mem[rd_addr];
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!hit && q[i].a == rd_addr) begin
          hit = 1'b1;
          v = q[i].d;
        end
      end
      if (!hit) begin
        exp_re = 1'b1; exp_addr = rd_addr;
      end
      r.due = cyc + 1 + LAT;
      r.d = v;
      rq.push_back(r);
    end
    if (wb_vld && exp_wbr) begin
      e.a = wb_addr; e.d = wb_wdata;
      q.push_back(e);
    end
    last_g = g;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; last_g = 0;
    exp_we = 1'b0; exp_re = 1'b0; exp_addr = '0; exp_data = '0;
    rst_n = 1'b0; ram_fill = 1'b1;
    idle();
    init_addr = '0; init_wdata = '0; rd_addr = '0; wb_addr = '0; wb_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    ram_fill = 1'b0;
    chk("rst_ctx_we", 32'(ctx_we), 32'd0);
    chk("rst_ctx_re", 32'(ctx_re), 32'd0);
    chk("rst_ctx_addr", 32'(ctx_addr), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_wb_rdy", 32'(wb_rdy), 32'd1);
    chk("rst_wb_empty", 32'(wb_empty), 32'd1);
    for (int i = 0; i < 1024; i++) ref_mem[i] = ram_init_val(i);
    rst_n = 1'b1;

    // Plain miss read of 0x012.
    rd_vld = 1'b1; rd_addr = 10'h012;
    step();
    chk("t1_ctx_re", 32'(ctx_re), 32'd1);
    chk("t1_ctx_addr", 32'(ctx_addr), 32'h012);
    idle();
    step();
    chk("t1_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("t1_rsp_data", 32'(rsp_data), 32'hA5);
    chk("t1_ctx_we", 32'(ctx_we), 32'd0);
    step();

    // Writeback then forwarded read of the same address.
    wb_vld = 1'b1; wb_addr = 10'h040; wb_wdata = 8'h3C;
    step();
    wb_vld = 1'b0; rd_vld = 1'b1; rd_addr = 10'h040;
    step();
    chk("t2_no_ctx_re", 32'(ctx_re), 32'd0);
    idle();
    step();
    chk("t2_ctx_we", 32'(ctx_we), 32'd1);
    chk("t2_ctx_addr", 32'(ctx_addr), 32'h040);
    chk("t2_ctx_wdata", 32'(ctx_wdata), 32'h3C);
    chk("t2_rsp_data", 32'(rsp_data), 32'h3C);
    step();

    // Same-cycle read and writeback: read sees the old memory value.
    rd_vld = 1'b1; rd_addr = 10'h050; wb_vld = 1'b1; wb_addr = 10'h050; wb_wdata = 8'h11;
    step();
    chk("t3_ctx_re", 32'(ctx_re), 32'd1);
    idle();
    step();
    chk("t3_rsp_data", 32'(rsp_data), 32'h22);
    chk("t3_ctx_we", 32'(ctx_we), 32'd1);
    chk("t3_ctx_wdata", 32'(ctx_wdata), 32'h11);
    repeat (2) step();

    // Streaming reads, one writeback per accepted read.
    for (int i = 0; i < 24; i++) begin
      rd_vld = 1'b1; rd_addr = 10'(10'h100 + i);
      wb_vld = (last_g == 2); wb_addr = 10'(10'h200 + i); wb_wdata = 8'($urandom);
      step();
    end
    idle();
    repeat (4) step();

    // Two buffered entries, then init and read together.
    for (int i = 0; i < 2; i++) begin
      rd_vld = 1'b1; rd_addr = 10'(10'h180 + i);
      wb_vld = 1'b1; wb_addr = 10'(10'h300 + i); wb_wdata = 8'($urandom);
      step();
    end
    wb_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      init_vld = 1'b1; init_addr = 10'(10'h000 + i); init_wdata = 8'($urandom);
      step();
    end
    init_vld = 1'b0;
    repeat (4) step();
    idle();
    repeat (4) step();

    // Asynchronous reset with two buffered entries and a read in flight.
    for (int i = 0; i < 2; i++) begin
      rd_vld = 1'b1; rd_addr = 10'(10'h3A0 + i);
      wb_vld = 1'b1; wb_addr = 10'(10'h3B0 + i); wb_wdata = 8'($urandom);
      step();
    end
    idle();
    #1;
    chk("t6_pre_wb_empty", 32'(wb_empty), 32'd0);
    chk("t6_pre_ctx_re", 32'(ctx_re), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_ctx_we", 32'(ctx_we), 32'd0);
    chk("t6_ctx_re", 32'(ctx_re), 32'd0);
    chk("t6_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("t6_wb_empty", 32'(wb_empty), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete(); rq.delete();
    exp_we = 1'b0; exp_re = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = ram[i];
    repeat (6) step();

    // Randomised traffic over a small address window to provoke hits.
    for (int i = 0; i < 1500; i++) begin
      init_vld   = ($urandom_range(0, 19) == 0);
      init_addr  = 10'($urandom_range(0, 31));
      init_wdata = 8'($urandom);
      rd_vld     = ($urandom_range(0, 9) < 7);
      rd_addr    = 10'($urandom_range(0, 31));
      wb_vld     = ($urandom_range(0, 1) == 0);
      wb_addr    = 10'($urandom_range(0, 31));
      wb_wdata   = 8'($urandom);
      step();
    end
    idle();
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
